// File: rtl/cpu0_jtag_debug_pkg.sv
// Shared types and defaults for the CPU0 JTAG debug command sequencer.
// Used by the top (macro CPU0_JTAG_DEBUG_CMD_FIFO_EN selects queue depth).
package cpu0_jtag_debug_pkg;

  localparam int IR_W_DEF = 2;
  localparam int SR_W_DEF = 38;
  localparam int ACT_BIT  = SR_W_DEF - 1;

  typedef struct packed {
    logic [IR_W_DEF-1:0] ir;
    logic [SR_W_DEF-1:0] sr;
  } cmd_entry_t;

endpackage

// File: rtl/cpu0_jtag_debug_tgl_sync.sv
// Toggle synchronizer plus registered edge detector.
// Emits a one-cycle event for every level change on i_tgl.
module cpu0_jtag_debug_tgl_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tgl,
  output logic o_evt
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_evt;
  logic                   w_lvl;

  assign w_lvl = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    r_sync <= {r_sync[SYNC_STAGES-2:0], i_tgl};
  end

  // Reset aligns the detector with the synchronized level: no false edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prev <= w_lvl;
      r_evt  <= 1'b0;
    end else begin
      r_prev <= w_lvl;
      r_evt  <= w_lvl ^ r_prev;
    end
  end

  assign o_evt = r_evt;

endmodule

// File: rtl/cpu0_jtag_debug_cmd_seq.sv
// JTAG debug command sequencer: uIR/uDR events feed a command queue.
// CPU0_JTAG_DEBUG_CMD_FIFO_EN: queue of FIFO_DEPTH, else single entry.
module cpu0_jtag_debug_cmd_seq
  import cpu0_jtag_debug_pkg::*;
#(
  parameter int IR_W        = IR_W_DEF,
  parameter int SR_W        = SR_W_DEF,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  localparam int N_CH       = 2**IR_W,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            uir_tgl,
  input  logic            udr_tgl,
  input  logic [IR_W-1:0] ir_in,
  input  logic [SR_W-1:0] sr,
  input  logic            cmd_ready,
  input  logic            ovf_clr,
  output logic            cmd_valid,
  output logic [IR_W-1:0] cmd_ir,
  output logic [SR_W-1:0] jdo,
  output logic [N_CH-1:0] take_action,
  output logic [N_CH-1:0] take_no_action,
  output logic [LW-1:0]   fifo_level,
  output logic            overflow
);

`ifdef CPU0_JTAG_DEBUG_CMD_FIFO_EN
  localparam int DEPTH = FIFO_DEPTH;
`else
  localparam int DEPTH = 1;
`endif
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << PW;

  logic            w_uir_evt;
  logic            w_udr_evt;
  logic            w_valid;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [N_CH-1:0] w_onehot;

  logic [IR_W-1:0] r_ir_lat;
  logic [IR_W-1:0] r_q_ir [SLOTS];
  logic [SR_W-1:0] r_q_sr [SLOTS];
  logic [PW-1:0]   r_wr;
  logic [PW-1:0]   r_rd;
  logic [LW-1:0]   r_level;
  logic            r_ovf;
  logic [SR_W-1:0] r_jdo;
  logic [N_CH-1:0] r_ta;
  logic [N_CH-1:0] r_tna;

  cpu0_jtag_debug_tgl_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_uir_sync (
    .i_clk   (clk),
    .i_reset (reset),
    .i_tgl   (uir_tgl),
    .o_evt   (w_uir_evt)
  );

  cpu0_jtag_debug_tgl_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_udr_sync (
    .i_clk   (clk),
    .i_reset (reset),
    .i_tgl   (udr_tgl),
    .o_evt   (w_udr_evt)
  );

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full queue still accepts a push when the head leaves that cycle.
  assign w_valid  = (r_level != '0);
  assign w_full   = (r_level == LW'(DEPTH));
  assign w_pop    = w_valid & cmd_ready;
  assign w_push   = w_udr_evt & (~w_full | w_pop);
  assign w_drop   = w_udr_evt & w_full & ~w_pop;
  assign w_onehot = N_CH'(1) << r_q_ir[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_ir[r_wr] <= r_ir_lat;
      r_q_sr[r_wr] <= sr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir_lat <= '0;
      r_wr     <= '0;
      r_rd     <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_uir_evt) r_ir_lat <= ir_in;
      if (w_push)    r_wr     <= f_inc(r_wr);
      if (w_pop)     r_rd     <= f_inc(r_rd);
      if (w_push && !w_pop)
        r_level <= r_level + LW'(1);
      else if (w_pop && !w_push)
        r_level <= r_level - LW'(1);
      if (w_drop)
        r_ovf <= 1'b1;
      else if (ovf_clr)
        r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_jdo <= '0;
      r_ta  <= '0;
      r_tna <= '0;
    end else begin
      r_ta  <= '0;
      r_tna <= '0;
      if (w_pop) begin
        r_jdo <= r_q_sr[r_rd];
        if (r_q_sr[r_rd][SR_W-1])
          r_ta  <= w_onehot;
        else
          r_tna <= w_onehot;
      end
    end
  end

  assign cmd_valid      = w_valid;
  assign cmd_ir         = r_q_ir[r_rd];
  assign jdo            = r_jdo;
  assign take_action    = r_ta;
  assign take_no_action = r_tna;
  assign fifo_level     = r_level;
  assign overflow       = r_ovf;

endmodule
